// File: rtl/alu_sequencer.sv
// Purpose:      sequences the shared 16-bit ALU for stack ALU instructions (BIN/UNARY/MUL/CMP),
//               then issues one stack update (pops + optional push) and registers the flags.
// Latency:      done two cycles after accept for BIN/UNARY/CMP, 17 for MUL, one on underflow.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while busy.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_kind 0=BIN 1=UNARY 2=MUL 3=CMP
//   cmd_alu_op                    ALU op for BIN/UNARY/CMP (MUL always uses OP_ADD)
//   tos, nos, depth               stack top/next and depth, sampled only at accept
//   alu_a, alu_b, alu_op          registered operands/op driven to the shared ALU
//   alu_q, alu_flags              ALU result and {carry,sign,zero}, combinational from alu_*
//   stack_we, pop_count, push,    one-cycle stack update strobe with its pop count,
//   push_data                     push enable and pushed value
//   flags                         {carry,sign,zero} of the last successfully completed op
//   done, error                   one-cycle completion pulse; error marks a depth underflow
module alu_sequencer #(
  parameter int         DEPTH_W = 5,
  parameter logic [5:0] OP_ADD  = 6'h09
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_kind,
  input  logic [5:0]         cmd_alu_op,
  input  logic [15:0]        tos,
  input  logic [15:0]        nos,
  input  logic [DEPTH_W-1:0] depth,
  output logic [15:0]        alu_a,
  output logic [15:0]        alu_b,
  output logic [5:0]         alu_op,
  input  logic [15:0]        alu_q,
  input  logic [2:0]         alu_flags,
  output logic               stack_we,
  output logic [1:0]         pop_count,
  output logic               push,
  output logic [15:0]        push_data,
  output logic [2:0]         flags,
  output logic               done,
  output logic               error
);

  localparam logic [1:0] KIND_BIN   = 2'd0;
  localparam logic [1:0] KIND_UNARY = 2'd1;
  localparam logic [1:0] KIND_MUL   = 2'd2;
  localparam logic [1:0] KIND_CMP   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WRITE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  kind_q;
  logic        err_q;
  logic [15:0] mplier;
  logic [15:0] result;
  logic [2:0]  cap_flags;
  logic [3:0]  cnt;
  logic        underflow;
  logic [15:0] mul_next;

  always_comb begin
    underflow = (cmd_kind == KIND_UNARY) ? (depth < DEPTH_W'(1)) : (depth < DEPTH_W'(2));
  end

  // In MUL, alu_a is the accumulator and alu_b the shifted multiplicand, so the
  // ALU sum is only taken when the current multiplier bit is set.
  assign mul_next  = mplier[0] ? alu_q : alu_a;
  assign push_data = result;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    stack_we  = 1'b0;
    pop_count = 2'd0;
    push      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (underflow)                  state_nxt = S_WRITE;
          else if (cmd_kind == KIND_MUL)  state_nxt = S_MUL;
          else                            state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_WRITE;
      S_MUL:  if (cnt == 4'd15) state_nxt = S_WRITE;
      S_WRITE: begin
        done      = 1'b1;
        error     = err_q;
        state_nxt = S_IDLE;
        if (!err_q) begin
          stack_we = 1'b1;
          case (kind_q)
            KIND_BIN, KIND_MUL: begin pop_count = 2'd2; push = 1'b1; end
            KIND_UNARY:         begin pop_count = 2'd1; push = 1'b1; end
            default:            begin pop_count = 2'd0; push = 1'b0; end // CMP: flags only
          endcase
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q    <= KIND_BIN;
      err_q     <= 1'b0;
      alu_a     <= 16'h0;
      alu_b     <= 16'h0;
      alu_op    <= 6'h0;
      mplier    <= 16'h0;
      result    <= 16'h0;
      cap_flags <= 3'b000;
      flags     <= 3'b000;
      cnt       <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            kind_q <= cmd_kind;
            err_q  <= underflow;
            cnt    <= 4'd0;
            if (cmd_kind == KIND_MUL) begin
              alu_a  <= 16'h0;
              alu_b  <= nos;
              alu_op <= OP_ADD;
              mplier <= tos;
            end else begin
              alu_a  <= (cmd_kind == KIND_UNARY) ? tos : nos;
              alu_b  <= tos;
              alu_op <= cmd_alu_op;
            end
          end
        end
        S_EXEC: begin
          result    <= alu_q;
          cap_flags <= alu_flags;
        end
        S_MUL: begin
          alu_a  <= mul_next;
          alu_b  <= alu_b << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            // Product is truncated to 16 bits; the adder carry is meaningless here.
            result    <= mul_next;
            cap_flags <= {1'b0, mul_next[15], (mul_next == 16'h0)};
          end
        end
        S_WRITE: begin
          if (!err_q) flags <= cap_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
